// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline buffer.
// Occupancy state encoding and count width.
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot of the pipeline buffer: load enable,
// synchronous clear and asynchronous reset to zero.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register, optional 2-entry skid buffer.
// Define BUBBLE_ZERO_EN to zero out_data and entries on bubbles/flush.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SKID  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  flush,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t      r_state;
    pipe_state_t      w_next;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_load;
    logic             w_skid_load;
    logic             w_clear;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_in_xfer && !w_out_xfer) begin
                    w_next = SKID ? ST_FULL : ST_BUSY;
                end else if (!w_in_xfer && w_out_xfer) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) w_next = ST_BUSY;
            end
            default: w_next = ST_EMPTY;
        endcase
        if (flush) w_next = ST_EMPTY;
    end

    // With SKID, in_ready is a pure function of state to cut the stall path.
    always_comb begin
        out_valid = (r_state != ST_EMPTY);
        if (SKID) begin
            in_ready = (r_state != ST_FULL) & ~reset;
        end else begin
            in_ready = (~out_valid | out_ready) & ~reset;
        end
        unique case (r_state)
            ST_EMPTY: count = 2'd0;
            ST_BUSY:  count = 2'd1;
            ST_FULL:  count = 2'd2;
            default:  count = 2'd0;
        endcase
    end

    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = in_data;
        if (!flush) begin
            unique case (r_state)
                ST_EMPTY: w_main_load = w_in_xfer;
                ST_BUSY: begin
                    w_main_load = w_in_xfer & w_out_xfer;
                    w_skid_load = w_in_xfer & ~w_out_xfer;
                end
                ST_FULL: begin
                    w_main_load = w_out_xfer;
                    w_main_d    = w_skid_q;
                end
                default: w_main_load = 1'b0;
            endcase
        end
    end

`ifdef BUBBLE_ZERO_EN
    assign w_clear  = flush;
    assign out_data = out_valid ? w_main_q : '0;
`else
    assign w_clear  = 1'b0;
    assign out_data = w_main_q;
`endif

    pipe_entry_reg #(
        .WIDTH (WIDTH)
    ) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_clear),
        .i_data  (w_main_d),
        .o_data  (w_main_q)
    );

    if (SKID) begin : g_skid
        pipe_entry_reg #(
            .WIDTH (WIDTH)
        ) u_skid (
            .clock   (clock),
            .reset   (reset),
            .i_load  (w_skid_load),
            .i_clear (w_clear),
            .i_data  (in_data),
            .o_data  (w_skid_q)
        );
    end else begin : g_noskid
        assign w_skid_q = '0;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, corner sequences and a
// queue-model scoreboard over three builds (W32/SKID1, W8/SKID0, W70/SKID1).
module tb_pipe_stage_buf;

    logic        clock;
    logic        reset;
    logic        iv   [3];
    logic        ordy [3];
    logic        fl   [3];
    logic [69:0] idat [3];
    logic        ir   [3];
    logic        ov   [3];
    logic [1:0]  cnt  [3];
    logic [31:0] od0;
    logic [7:0]  od1;
    logic [69:0] od2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t tv [15];

    logic [69:0] mdat [3][2];
    int          msz  [3];
    logic        mir  [3];

    pipe_stage_buf #(.WIDTH(32), .SKID(1'b1)) u_d0 (
        .clock(clock), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][31:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
        .flush(fl[0]), .count(cnt[0])
    );

    pipe_stage_buf #(.WIDTH(8), .SKID(1'b0)) u_d1 (
        .clock(clock), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][7:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
        .flush(fl[1]), .count(cnt[1])
    );

    pipe_stage_buf #(.WIDTH(70), .SKID(1'b1)) u_d2 (
        .clock(clock), .reset(reset),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
        .flush(fl[2]), .count(cnt[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [69:0] odv(int k);
        if (k == 0) return {38'b0, od0};
        if (k == 1) return {62'b0, od1};
        return od2;
    endfunction

    function automatic logic [69:0] msk(int k);
        if (k == 0) return {38'b0, {32{1'b1}}};
        if (k == 1) return {62'b0, 8'hFF};
        return {70{1'b1}};
    endfunction

    function automatic vec_t mk(logic v, logic [31:0] d, logic r,
                                logic f, logic eov, logic [31:0] eod,
                                logic [1:0] ec, logic eir);
        vec_t t;
        t.iv = v; t.d = d; t.ordy = r; t.fl = f;
        t.e_ov = eov; t.e_od = eod; t.e_cnt = ec; t.e_ir = eir;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act,
                       input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; idat[k] = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ix, ox;
        tv[0]  = mk(1, 32'h11, 1, 0, 1, 32'h11, 1, 1);
        tv[1]  = mk(1, 32'h22, 1, 0, 1, 32'h22, 1, 1);
        tv[2]  = mk(1, 32'h33, 1, 0, 1, 32'h33, 1, 1);
        tv[3]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 0, 1);
        tv[4]  = mk(1, 32'hA1, 0, 0, 1, 32'hA1, 1, 1);
        tv[5]  = mk(1, 32'hA2, 0, 0, 1, 32'hA1, 2, 0);
        tv[6]  = mk(1, 32'hA3, 0, 0, 1, 32'hA1, 2, 0);
        tv[7]  = mk(0, 32'h00, 1, 0, 1, 32'hA2, 1, 1);
        tv[8]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 0, 1);
        tv[9]  = mk(1, 32'hC1, 0, 0, 1, 32'hC1, 1, 1);
        tv[10] = mk(1, 32'hC2, 0, 0, 1, 32'hC1, 2, 0);
        tv[11] = mk(1, 32'hBB, 0, 1, 0, 32'h00, 0, 1);
        tv[12] = mk(1, 32'hD1, 0, 0, 1, 32'hD1, 1, 1);
        tv[13] = mk(1, 32'hBB, 1, 1, 0, 32'h00, 0, 1);
        tv[14] = mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 1);

        idle();
        reset = 1'b1;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 70'(ir[k]), 70'd0);
            chk("rst_out_valid", 70'(ov[k]), 70'd0);
            chk("rst_count", 70'(cnt[k]), 70'd0);
            chk("rst_out_data", odv(k), 70'd0);
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("rel_in_ready", 70'(ir[k]), 70'd1);
        @(posedge clock); #1;

        for (int i = 0; i < 15; i++) begin
            iv[0] = tv[i].iv; idat[0] = 70'(tv[i].d);
            ordy[0] = tv[i].ordy; fl[0] = tv[i].fl;
            @(posedge clock); #1;
            chk($sformatf("vec%0d_valid", i), 70'(ov[0]), 70'(tv[i].e_ov));
            chk($sformatf("vec%0d_count", i), 70'(cnt[0]), 70'(tv[i].e_cnt));
            chk($sformatf("vec%0d_ready", i), 70'(ir[0]), 70'(tv[i].e_ir));
            if (tv[i].e_ov)
                chk($sformatf("vec%0d_data", i), odv(0), 70'(tv[i].e_od));
`ifdef BUBBLE_ZERO_EN
            else
                chk($sformatf("vec%0d_bubble", i), odv(0), 70'd0);
`endif
        end
        idle();

        // Fill to FULL, then probe in_ready against out_ready and async reset.
        iv[0] = 1'b1; idat[0] = 70'hE1;
        @(posedge clock); #1;
        idat[0] = 70'hE2;
        @(posedge clock); #1;
        iv[0] = 1'b0;
        chk("full_count", 70'(cnt[0]), 70'd2);
        ordy[0] = 1'b1; #1;
        chk("full_ready_or1", 70'(ir[0]), 70'd0);
        ordy[0] = 1'b0; #1;
        chk("full_ready_or0", 70'(ir[0]), 70'd0);
        reset = 1'b1; #1;
        chk("arst_valid", 70'(ov[0]), 70'd0);
        chk("arst_count", 70'(cnt[0]), 70'd0);
        chk("arst_ready", 70'(ir[0]), 70'd0);
        reset = 1'b0;
        iv[0] = 1'b1; idat[0] = 70'h5C; ordy[0] = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_valid", 70'(ov[0]), 70'd1);
        chk("post_rst_data", odv(0), 70'h5C);
        chk("post_rst_count", 70'(cnt[0]), 70'd1);
        iv[0] = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_drain", 70'(ov[0]), 70'd0);

        // Single-entry build: combinational in_ready and replace-on-pop.
        iv[1] = 1'b1; idat[1] = 70'h66; ordy[1] = 1'b0;
        @(posedge clock); #1;
        iv[1] = 1'b0;
        chk("s0_valid", 70'(ov[1]), 70'd1);
        chk("s0_data", odv(1), 70'h66);
        #1;
        chk("s0_ready_stall", 70'(ir[1]), 70'd0);
        ordy[1] = 1'b1; #1;
        chk("s0_ready_go", 70'(ir[1]), 70'd1);
        iv[1] = 1'b1; idat[1] = 70'h77;
        @(posedge clock); #1;
        chk("s0_replace_data", odv(1), 70'h77);
        chk("s0_replace_count", 70'(cnt[1]), 70'd1);
        iv[1] = 1'b0;
        @(posedge clock); #1;
        chk("s0_drain", 70'(cnt[1]), 70'd0);
        idle();

        for (int k = 0; k < 3; k++) msz[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = ($urandom % 4) != 0;
                ordy[k] = ($urandom % 3) != 0;
                fl[k]   = ($urandom % 64) == 0;
                idat[k] = {$urandom, $urandom, $urandom} & msk(k);
            end
            #2;
            for (int k = 0; k < 3; k++) begin
                if (k == 1) mir[k] = (msz[k] == 0) || ordy[k];
                else        mir[k] = msz[k] < 2;
                chk("rnd_ready", 70'(ir[k]), 70'(mir[k]));
                chk("rnd_valid", 70'(ov[k]), 70'(msz[k] > 0));
                chk("rnd_count", 70'(cnt[k]), 70'(msz[k]));
                if (msz[k] > 0) chk("rnd_data", odv(k), mdat[k][0]);
`ifdef BUBBLE_ZERO_EN
                else chk("rnd_bubble", odv(k), 70'd0);
`endif
            end
            @(posedge clock);
            for (int k = 0; k < 3; k++) begin
                ix = iv[k] & mir[k];
                ox = (msz[k] > 0) & ordy[k];
                if (fl[k]) begin
                    msz[k] = 0;
                end else begin
                    if (ox) begin
                        mdat[k][0] = mdat[k][1];
                        msz[k]--;
                    end
                    if (ix) begin
                        mdat[k][msz[k]] = idat[k];
                        msz[k]++;
                    end
                end
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
